arbiter_rr_n: RTL and testbench

N-way round-robin arbiter with a registered output stage and per-grant burst limit. It shares one valid/ready downstream consumer among N valid/ready producers. It sits where the existing two-input arbiter is too narrow, for example when merging per-engine result streams into a single result channel. Arbitration is work-conserving: no cycle is lost while any input is valid and the output can accept.

---
 rtl/arbiter_pkg.sv | 13 +
 rtl/rr_select.sv | 45 ++++
 rtl/arbiter_rr_n.sv | 103 ++++++++++
 tb/tb_arbiter_rr_n.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arbiter_pkg.sv
// Shared definitions for the arbiter family: id width helper and a common id type.
package arbiter_pkg;

    localparam int ARB_ID_MAX_W = 8;

    typedef logic [ARB_ID_MAX_W-1:0] arb_id_t;

    // Index width for n requesters, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin pick: first set request at or after i_ptr, wrapping.
module rr_select
    import arbiter_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = id_width(N)
) (
    input  logic [N-1:0]   i_req,
    input  logic [IDW-1:0] i_ptr,
    output logic [N-1:0]   o_gnt,
    output logic [IDW-1:0] o_idx,
    output logic           o_any
);

    logic [2*N-1:0] w_dbl;
    logic [IDW-1:0] w_idx;
    logic           w_found;
    logic [N-1:0]   w_gnt;

    assign w_dbl = {i_req, i_req};

    // Masking the low copy below i_ptr lets the upper copy supply the wrapped requests.
    always_comb begin
        w_idx   = '0;
        w_found = 1'b0;
        for (int j = 0; j < 2 * N; j++) begin
            if (!w_found && w_dbl[j] && (j >= int'(i_ptr))) begin
                w_found = 1'b1;
                w_idx   = IDW'(j % N);
            end
        end
    end

    always_comb begin
        w_gnt = '0;
        for (int i = 0; i < N; i++) begin
            w_gnt[i] = w_found && (w_idx == IDW'(i));
        end
    end

    assign o_gnt = w_gnt;
    assign o_idx = w_idx;
    assign o_any = w_found;

endmodule

// File: rtl/arbiter_rr_n.sv
// N-way round-robin arbiter feeding one registered valid/ready output, with a per-input burst limit.
// Handshake: a beat moves on any edge where valid & ready are both high; out_valid/out_data/out_id hold while out_ready is low.
module arbiter_rr_n
    import arbiter_pkg::*;
#(
    parameter  int DWIDTH = 16,
    parameter  int N      = 4,
    parameter  int BURST  = 1,
    localparam int IDW    = id_width(N),
    localparam int CW     = $clog2(BURST + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N-1:0]        in_valid,
    input  logic [N*DWIDTH-1:0] in_data,
    output logic [N-1:0]        in_ready,
    output logic                out_valid,
    output logic [DWIDTH-1:0]   out_data,
    output logic [IDW-1:0]      out_id,
    input  logic                out_ready
);

    logic              r_out_valid;
    logic [DWIDTH-1:0] r_out_data;
    logic [IDW-1:0]    r_out_id;
    logic [IDW-1:0]    r_ptr;
    logic [CW-1:0]     r_cnt;
    logic [IDW-1:0]    r_last;

    logic [N-1:0]      w_gnt;
    logic [IDW-1:0]    w_idx;
    logic              w_any;
    logic              w_accept;
    logic              w_xfer;
    logic [DWIDTH-1:0] w_sel_data;
    logic [CW-1:0]     w_cnt_n;
    logic [IDW-1:0]    w_ptr_wrap;
    logic [IDW-1:0]    w_ptr_next;
    logic [CW-1:0]     w_cnt_next;

    rr_select #(
        .N   (N),
        .IDW (IDW)
    ) u_rr_select (
        .i_req (in_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign w_accept = !r_out_valid || out_ready;
    // Reset gates ready directly so no producer sees a handshake while the block is held.
    assign w_xfer   = w_accept && w_any && !reset;
    assign in_ready = w_gnt & {N{w_xfer}};

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_gnt[i]) begin
                w_sel_data = in_data[i*DWIDTH +: DWIDTH];
            end
        end
    end

    assign w_ptr_wrap = (w_idx == IDW'(N - 1)) ? '0 : w_idx + IDW'(1);

    // Repeat grants to the same input extend its burst; reaching the limit hands priority onward.
    always_comb begin
        w_cnt_n    = (w_idx == r_last) ? r_cnt + CW'(1) : CW'(1);
        w_ptr_next = w_idx;
        w_cnt_next = w_cnt_n;
        if (w_cnt_n == CW'(BURST)) begin
            w_ptr_next = w_ptr_wrap;
            w_cnt_next = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_id    <= '0;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_last      <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_out_id    <= w_idx;
            r_ptr       <= w_ptr_next;
            r_cnt       <= w_cnt_next;
            r_last      <= w_idx;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_id    = r_out_id;

endmodule

// File: tb/tb_arbiter_rr_n.sv
// Bench for arbiter_rr_n: BURST=1 and BURST=2 instances share stimulus and are checked against a behavioural model.
module tb_arbiter_rr_n;

    localparam int N  = 4;
    localparam int DW = 16;

    logic            clk;
    logic            rst;
    logic [N-1:0]    in_valid;
    logic [N*DW-1:0] in_data;
    logic            out_ready;

    logic [N-1:0]  rdy1, rdy2;
    logic          ov1, ov2;
    logic [DW-1:0] od1, od2;
    logic [1:0]    oid1, oid2;

    int  n_tests;
    int  n_fail;
    bit  chk_en;

    int            burst_of [2];
    int            m_ptr    [2];
    int            m_cnt    [2];
    int            m_last   [2];
    bit            m_ov     [2];
    logic [DW-1:0] m_od     [2];
    int            m_oid    [2];

    int seq2 [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    int sk1  [4] = '{1, 3, 1, 3};
    int sk2  [4] = '{1, 1, 3, 3};
    int dr1  [4] = '{3, 0, 2, 3};
    int dr2  [4] = '{2, 2, 3, 3};
    int ms2  [5] = '{0, 0, 1, 1, 2};

    arbiter_rr_n #(.DWIDTH(DW), .N(N), .BURST(1)) u_dut1 (
        .clk       (clk),
        .reset     (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (rdy1),
        .out_valid (ov1),
        .out_data  (od1),
        .out_id    (oid1),
        .out_ready (out_ready)
    );

    arbiter_rr_n #(.DWIDTH(DW), .N(N), .BURST(2)) u_dut2 (
        .clk       (clk),
        .reset     (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (rdy2),
        .out_valid (ov2),
        .out_data  (od2),
        .out_id    (oid2),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic all_valid();
        in_valid = 4'b1111;
        for (int i = 0; i < N; i++) in_data[i*DW +: DW] = 16'hA000 + 16'(i);
    endtask

    // First valid input scanning ptr, ptr+1, ... modulo N; -1 when none valid.
    function automatic int winner(input int b);
        for (int k = 0; k < N; k++) begin
            if (in_valid[(m_ptr[b] + k) % N]) return (m_ptr[b] + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready(input int b);
        logic [N-1:0] r;
        int w;
        r = '0;
        w = winner(b);
        if (!rst && w >= 0 && (!m_ov[b] || out_ready)) r[w] = 1'b1;
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                m_ptr[b] = 0; m_cnt[b] = 0; m_last[b] = 0;
                m_ov[b] = 1'b0; m_od[b] = '0; m_oid[b] = 0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                int w;
                int nn;
                w = winner(b);
                if ((!m_ov[b] || out_ready) && w >= 0) begin
                    m_ov[b]  = 1'b1;
                    m_od[b]  = in_data[w*DW +: DW];
                    m_oid[b] = w;
                    nn = (w == m_last[b]) ? m_cnt[b] + 1 : 1;
                    if (nn == burst_of[b]) begin
                        m_ptr[b] = (w + 1) % N;
                        m_cnt[b] = 0;
                    end else begin
                        m_ptr[b] = w;
                        m_cnt[b] = nn;
                    end
                    m_last[b] = w;
                end else if (m_ov[b] && out_ready) begin
                    m_ov[b] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_rdy1", rdy1, exp_ready(0));
            check("cmp_ov1",  ov1,  m_ov[0]);
            check("cmp_od1",  od1,  m_od[0]);
            check("cmp_oid1", oid1, m_oid[0]);
            check("cmp_rdy2", rdy2, exp_ready(1));
            check("cmp_ov2",  ov2,  m_ov[1]);
            check("cmp_od2",  od2,  m_od[1]);
            check("cmp_oid2", oid2, m_oid[1]);
        end
    end

    initial begin
        n_tests = 0;
        n_fail = 0;
        chk_en = 1'b0;
        burst_of[0] = 1;
        burst_of[1] = 2;
        rst = 1'b1;
        in_valid = '0;
        in_data = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("rst_ov1", ov1, 1'b0);
        check("rst_od1", od1, 16'h0000);
        check("rst_rdy1", rdy1, 4'b0000);
        rst = 1'b0;

        // Rotation (BURST=1) and bursts (BURST=2) from reset, all inputs valid.
        all_valid();
        out_ready = 1'b1;
        #1;
        check("first_rdy1", rdy1, 4'b0001);
        check("first_rdy2", rdy2, 4'b0001);
        for (int k = 0; k < 9; k++) begin
            step();
            check("rot_id1", oid1, k % 4);
            check("rot_od1", od1, 16'hA000 + 16'(k % 4));
            check("bur_id2", oid2, seq2[k]);
        end

        in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            step();
            check("skip_id1", oid1, sk1[k]);
            check("skip_id2", oid2, sk2[k]);
        end

        in_valid = 4'b0100;
        in_data[2*DW +: DW] = 16'hBEEF;
        for (int k = 0; k < 4; k++) begin
            step();
            check("single_ov1", ov1, 1'b1);
            check("single_od1", od1, 16'hBEEF);
            check("single_id1", oid1, 2);
            check("single_id2", oid2, 2);
        end

        // Mid-cycle reset; outputs and readies drop at once.
        #2;
        rst = 1'b1;
        #1;
        check("arst_ov1", ov1, 1'b0);
        check("arst_ov2", ov2, 1'b0);
        check("arst_rdy1", rdy1, 4'b0000);
        check("arst_rdy2", rdy2, 4'b0000);
        step();
        step();
        rst = 1'b0;
        all_valid();
        #1;
        check("rel_rdy2", rdy2, 4'b0001);
        for (int k = 0; k < 3; k++) begin
            step();
            check("pre_id1", oid1, k);
            check("pre_id2", oid2, seq2[k]);
        end
        in_valid = 4'b1101;
        for (int k = 0; k < 4; k++) begin
            step();
            check("drop_id1", oid1, dr1[k]);
            check("drop_id2", oid2, dr2[k]);
        end

        // Reset in the middle of a burst on input 2.
        #2;
        rst = 1'b1;
        step();
        rst = 1'b0;
        all_valid();
        for (int k = 0; k < 5; k++) begin
            step();
            check("mid_id2", oid2, ms2[k]);
        end
        #2;
        rst = 1'b1;
        #1;
        check("mid_lost_ov2", ov2, 1'b0);
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("resume_id2", oid2, seq2[k]);
        end

        // Backpressure: item held, readies low, pointers frozen.
        #2;
        rst = 1'b1;
        step();
        rst = 1'b0;
        all_valid();
        in_data[0 +: DW] = 16'hDEAD;
        out_ready = 1'b0;
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            check("bp_ov1", ov1, 1'b1);
            check("bp_od1", od1, 16'hDEAD);
            check("bp_od2", od2, 16'hDEAD);
            check("bp_rdy1", rdy1, 4'b0000);
            check("bp_rdy2", rdy2, 4'b0000);
        end
        out_ready = 1'b1;
        #1;
        check("bp_rel_rdy1", rdy1, 4'b0010);
        check("bp_rel_rdy2", rdy2, 4'b0001);
        step();
        check("bp_refill_id1", oid1, 1);
        check("bp_refill_od1", od1, 16'hA001);
        check("bp_refill_id2", oid2, 0);
        check("bp_refill_ov2", ov2, 1'b1);

        // Randomized traffic, checked every cycle by the compare process.
        for (int c = 0; c < 3000; c++) begin
            step();
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) != 0) in_valid = 4'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) in_data[i*DW +: DW] = 16'($urandom_range(0, 65535));
            out_ready = ($urandom_range(0, 3) != 0);
        end
        rst = 1'b0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
